// File: rtl/mem_bus_pkg.sv
// Shared definitions for the byte-addressed core/GPU memory bus and its slaves.
// Holds bus widths, response-entry layout, error-counter width and region bases.
package mem_bus_pkg;

   localparam int BW        = 32;
   localparam int DW_DEF    = 32;
   localparam int ERR_CNT_W = 16;

   localparam logic [BW-1:0] BRAM_BASE   = 32'h0000_0000;
   localparam logic [BW-1:0] PERIPH_BASE = 32'h1000_0000;

   typedef struct packed {
      logic [DW_DEF-1:0] rdata;
      logic              err;
   } rsp_entry_t;

endpackage

// File: rtl/rsp_fifo2.sv
// Two-entry in-order FIFO carrying bus responses; head_data shows the oldest entry.
// The caller never pushes into a full FIFO unless it pops in the same cycle.
module rsp_fifo2 #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head_data,
   output logic [1:0]   count
);

   logic [W-1:0] entries [2];
   logic         wr_ptr;
   logic         rd_ptr;

   // NOTE: the two storage entries are reset as well so the head reads as zero
   // while in reset; for a 2-deep FIFO that costs almost nothing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entries[0] <= '0;
         entries[1] <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= 2'd0;
      end else begin
         if (push) begin
            entries[wr_ptr] <= push_data;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: ;
         endcase
      end
   end

   assign head_data = entries[rd_ptr];

endmodule

// File: rtl/bram_bus_slave.sv
// Bus front end for a single-port byte-writable BRAM with combinational read.
// Decodes/aligns each command, drives the BRAM pins and queues one response per command.
module bram_bus_slave
   import mem_bus_pkg::*;
#(
   parameter int              DP        = 512,
   parameter int              DW        = 32,
   parameter int              MW        = DW / 8,
   parameter int              AW        = $clog2(DP),
   parameter logic [BW-1:0]   BASE_ADDR = BRAM_BASE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [BW-1:0]        cmd_addr,
   input  logic                 cmd_read,
   input  logic [DW-1:0]        cmd_wdata,
   input  logic [MW-1:0]        cmd_wmask,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DW-1:0]        rsp_rdata,
   output logic                 rsp_err,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [AW-1:0]        bram_addr,
   output logic [DW-1:0]        bram_wdata,
   output logic [MW-1:0]        bram_sel,
   output logic                 bram_we,
   input  logic [DW-1:0]        bram_rdata
);

   localparam int            LW   = $clog2(MW);
   localparam logic [BW-1:0] SPAN = BW'(DP * MW);

   logic [BW-1:0] offset;
   logic          err;
   logic          accept;
   logic          pop;
   logic [1:0]    fifo_count;
   logic [DW:0]   push_data;
   logic [DW:0]   head_data;

   // An address below the base wraps to a huge offset and lands in the error range.
   assign offset = cmd_addr - BASE_ADDR;
   assign err    = (offset >= SPAN) | (offset[LW-1:0] != '0);

   assign bram_addr  = offset[LW+AW-1:LW];
   assign bram_wdata = cmd_wdata;
   assign bram_sel   = cmd_wmask;

   // cmd_ready depends on registered occupancy only, never on rsp_ready.
   assign cmd_ready = (fifo_count != 2'd2);
   assign accept    = cmd_valid & cmd_ready & rst_n;
   assign bram_we   = accept & ~cmd_read & ~err;

   assign push_data = {(cmd_read & ~err) ? bram_rdata : '0, err};
   assign rsp_valid = (fifo_count != 2'd0);
   assign pop       = rsp_valid & rsp_ready;

   rsp_fifo2 #(.W(DW + 1)) u_rsp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (accept),
      .push_data (push_data),
      .pop       (pop),
      .head_data (head_data),
      .count     (fifo_count)
   );

   assign rsp_rdata = head_data[DW:1];
   assign rsp_err   = head_data[0];

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (accept && err && (err_cnt != '1)) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule
